// File: rtl/seq_matmul_mp.sv
`default_nettype none
// ============================================================================
// seq_matmul_mp : digit-serial mixed-precision matrix MAC, D = A*B + (C | D_prev)
// Flattened operands: element [r][c] of an R x C matrix sits at index r*C+c.
// Revision 1.0
// ============================================================================

module seq_matmul_mp #(
  parameter int M         = 2,
  parameter int N         = 2,
  parameter int K         = 2,
  parameter int MAX_WIDTH = 16,
  parameter int P         = 2,
  parameter int ACC_W     = 32,
  localparam int WB       = $clog2(MAX_WIDTH) + 1
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [M*K*MAX_WIDTH-1:0]   a_i,
  input  logic [K*N*MAX_WIDTH-1:0]   b_i,
  input  logic [M*N*ACC_W-1:0]       c_i,
  input  logic [WB-1:0]              a_bits_i,
  input  logic [WB-1:0]              b_bits_i,
  input  logic                       signed_i,
  input  logic                       acc_keep_i,
  input  logic                       valid_i,
  output logic                       ready_o,
  output logic                       valid_o,
  output logic [M*N*ACC_W-1:0]       d_o,
  input  logic                       ready_i
);

  localparam int ND_MAX = MAX_WIDTH / P;
  localparam int CW     = $clog2(ND_MAX + 1);
  localparam int IW     = $clog2(MAX_WIDTH);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COMPUTE = 2'd1,
    S_DONE    = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [MAX_WIDTH-1:0] a_q   [M*K];
  logic [ACC_W-1:0]     b_q   [K*N];
  logic [ACC_W-1:0]     acc_q [M*N];
  logic [ACC_W-1:0]     acc_d [M*N];
  logic [ACC_W-1:0]     d_q   [M*N];
  logic [CW-1:0]        dig_q, nd_q;
  logic                 signed_q;

  logic                 accept;
  int                   a_w, b_w, sh;
  logic [CW-1:0]        nd_in;
  logic [MAX_WIDTH-1:0] a_mask, b_mask, b_raw;
  logic [ACC_W-1:0]     b_ext_mask, b_ext;
  logic [MAX_WIDTH-1:0] a_in  [M*K];
  logic [ACC_W-1:0]     b_in  [K*N];
  logic                 sbit, last_sgn;
  logic [P-1:0]         dg;
  logic [ACC_W-1:0]     dext;

  assign ready_o = rst_ni & ((state_q == S_IDLE) | ((state_q == S_DONE) & ready_i));
  assign valid_o = (state_q == S_DONE);
  assign accept  = valid_i & ready_o;

  always_comb begin
    d_o = '0;
    for (int i = 0; i < M*N; i++) d_o[i*ACC_W +: ACC_W] = d_q[i];
  end

  // Width sanitising and operand conditioning for the accept cycle.
  always_comb begin
    a_w = int'(a_bits_i);
    if (a_w == 0 || a_w > MAX_WIDTH) a_w = MAX_WIDTH;
    a_w = ((a_w + P - 1) / P) * P;
    nd_in = CW'(a_w / P);
    b_w = int'(b_bits_i);
    if (b_w == 0 || b_w > MAX_WIDTH) b_w = MAX_WIDTH;
    a_mask     = MAX_WIDTH'((64'd1 << a_w) - 64'd1);
    b_mask     = MAX_WIDTH'((64'd1 << b_w) - 64'd1);
    b_ext_mask = {{(ACC_W-MAX_WIDTH){1'b0}}, b_mask};
    b_raw = '0;
    b_ext = '0;
    sbit  = 1'b0;
    for (int i = 0; i < M*K; i++) a_in[i] = a_i[i*MAX_WIDTH +: MAX_WIDTH] & a_mask;
    for (int i = 0; i < K*N; i++) begin
      b_raw   = b_i[i*MAX_WIDTH +: MAX_WIDTH];
      sbit    = signed_i & b_raw[IW'(b_w - 1)];
      b_ext   = {{(ACC_W-MAX_WIDTH){1'b0}}, b_raw & b_mask};
      b_in[i] = sbit ? (b_ext | ~b_ext_mask) : b_ext;
    end
  end

  // One A digit per cycle; the top digit carries the sign in signed mode.
  always_comb begin
    last_sgn = signed_q & ((dig_q + CW'(1)) == nd_q);
    sh       = int'(dig_q) * P;
    dg       = '0;
    dext     = '0;
    for (int i = 0; i < M*N; i++) acc_d[i] = acc_q[i];
    for (int m = 0; m < M; m++) begin
      for (int n = 0; n < N; n++) begin
        for (int k = 0; k < K; k++) begin
          dg   = P'(a_q[m*K+k] >> sh);
          dext = {{(ACC_W-P){last_sgn & dg[P-1]}}, dg};
          acc_d[m*N+n] = acc_d[m*N+n] + ((dext * b_q[k*N+n]) << sh);
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (accept) state_d = S_COMPUTE;
      S_COMPUTE: if (dig_q == nd_q) state_d = S_DONE;
      S_DONE:    if (ready_i) state_d = valid_i ? S_COMPUTE : S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      dig_q    <= '0;
      nd_q     <= '0;
      signed_q <= 1'b0;
      for (int i = 0; i < M*K; i++) a_q[i] <= '0;
      for (int i = 0; i < K*N; i++) b_q[i] <= '0;
      for (int i = 0; i < M*N; i++) begin
        acc_q[i] <= '0;
        d_q[i]   <= '0;
      end
    end else begin
      state_q <= state_d;
      if (accept) begin
        dig_q    <= '0;
        nd_q     <= nd_in;
        signed_q <= signed_i;
        for (int i = 0; i < M*K; i++) a_q[i] <= a_in[i];
        for (int i = 0; i < K*N; i++) b_q[i] <= b_in[i];
        for (int i = 0; i < M*N; i++)
          acc_q[i] <= acc_keep_i ? d_q[i] : c_i[i*ACC_W +: ACC_W];
      end else if (state_q == S_COMPUTE) begin
        // Extra cycle after the last digit publishes the accumulator.
        if (dig_q != nd_q) begin
          dig_q <= dig_q + CW'(1);
          for (int i = 0; i < M*N; i++) acc_q[i] <= acc_d[i];
        end else begin
          for (int i = 0; i < M*N; i++) d_q[i] <= acc_q[i];
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_seq_matmul_mp.sv
`default_nettype none
// ============================================================================
// tb_seq_matmul_mp : scoreboard bench for seq_matmul_mp (directed + random ops)
// Revision 1.0
// ============================================================================

module tb_seq_matmul_mp;

  localparam int M = 2, N = 2, K = 2, W = 16, P = 2, AW = 32, WB = 5;

  logic              clk = 1'b0;
  logic              rst_ni = 1'b0;
  logic [M*K*W-1:0]  a_i = '0;
  logic [K*N*W-1:0]  b_i = '0;
  logic [M*N*AW-1:0] c_i = '0;
  logic [WB-1:0]     a_bits_i = '0;
  logic [WB-1:0]     b_bits_i = '0;
  logic              signed_i = 1'b0;
  logic              acc_keep_i = 1'b0;
  logic              valid_i = 1'b0;
  logic              ready_o;
  logic              valid_o;
  logic [M*N*AW-1:0] d_o;
  logic              ready_i;
  logic              ready_cmd = 1'b1;
  logic              rnd_rdy = 1'b0;
  logic              rnd_bit = 1'b0;

  assign ready_i = rnd_rdy ? rnd_bit : ready_cmd;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [127:0] exp_d[$];
  int           exp_cyc[$];
  logic [127:0] last_d = '0;

  seq_matmul_mp #(.M(M), .N(N), .K(K), .MAX_WIDTH(W), .P(P), .ACC_W(AW)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .a_i(a_i), .b_i(b_i), .c_i(c_i),
    .a_bits_i(a_bits_i), .b_bits_i(b_bits_i), .signed_i(signed_i),
    .acc_keep_i(acc_keep_i), .valid_i(valid_i), .ready_o(ready_o),
    .valid_o(valid_o), .d_o(d_o), .ready_i(ready_i)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial forever begin
    @(posedge clk);
    #1 rnd_bit = 1'($urandom_range(0, 1));
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, required self-termination");
    $fatal(1);
  end

  function automatic logic [63:0] p16(input int e0, e1, e2, e3);
    return {e3[15:0], e2[15:0], e1[15:0], e0[15:0]};
  endfunction

  function automatic logic [127:0] p32(input int e0, e1, e2, e3);
    return {e3[31:0], e2[31:0], e1[31:0], e0[31:0]};
  endfunction

  function automatic int eff_a(input int ab);
    int ae;
    ae = (ab == 0 || ab > W) ? W : ab;
    return ((ae + P - 1) / P) * P;
  endfunction

  // D = A*B + addend with A, B interpreted as integers of their effective widths.
  function automatic logic [127:0] model(input logic [63:0] av, bv, input logic [127:0] cv,
                                         input int ab, bb, input bit sg, kp,
                                         input logic [127:0] prev);
    int ae, be;
    longint s, x, y;
    logic [127:0] d;
    ae = eff_a(ab);
    be = (bb == 0 || bb > W) ? W : bb;
    d  = '0;
    for (int m = 0; m < M; m++) begin
      for (int n = 0; n < N; n++) begin
        s = kp ? longint'(prev[(m*N+n)*AW +: AW]) : longint'(cv[(m*N+n)*AW +: AW]);
        for (int k = 0; k < K; k++) begin
          x = longint'(av[(m*K+k)*W +: W]) & ((64'sd1 << ae) - 1);
          if (sg && x[ae-1]) x = x - (64'sd1 << ae);
          y = longint'(bv[(k*N+n)*W +: W]) & ((64'sd1 << be) - 1);
          if (sg && y[be-1]) y = y - (64'sd1 << be);
          s = s + x * y;
        end
        d[(m*N+n)*AW +: AW] = s[AW-1:0];
      end
    end
    return d;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, expv);
    end
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic issue(input logic [63:0] av, bv, input logic [127:0] cv,
                       input int ab, bb, input bit sg, kp, use_exp,
                       input logic [127:0] dexp, output int acc_cyc);
    int n;
    logic [127:0] d;
    a_i = av; b_i = bv; c_i = cv;
    a_bits_i = WB'(ab); b_bits_i = WB'(bb);
    signed_i = sg; acc_keep_i = kp; valid_i = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ready_o && n < 200);
    acc_cyc = cyc + 1;
    if (!ready_o) begin
      checks++; errors++;
      $display("FAIL accept_timeout: ready_o=0 after %0d cycles, required 1", n);
      valid_i = 1'b0;
      return;
    end
    d = use_exp ? dexp : model(av, bv, cv, ab, bb, sg, kp, last_d);
    exp_d.push_back(d);
    exp_cyc.push_back(acc_cyc + eff_a(ab) / P + 1);
    last_d = d;
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    a_i = {$urandom, $urandom}; b_i = {$urandom, $urandom};
    c_i = {$urandom, $urandom, $urandom, $urandom};
    a_bits_i = WB'($urandom); b_bits_i = WB'($urandom);
    signed_i = 1'($urandom); acc_keep_i = 1'($urandom);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_d.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (exp_d.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", exp_d.size());
      exp_d.delete();
      exp_cyc.delete();
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops the scoreboard when a new result appears.
  initial begin
    logic         pv;
    logic [127:0] held;
    pv = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (valid_o && !pv) begin
        if (exp_d.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_result: valid_o=1 d_o=0x%0h, required no result", d_o);
        end else begin
          chk("result_d", d_o, exp_d.pop_front());
          chk("result_latency", 128'(cyc), 128'(exp_cyc.pop_front()));
        end
      end else if (valid_o && pv) begin
        chk("d_stable", d_o, held);
      end
      if (valid_o) chk("ready_o_in_done", 128'(ready_o), 128'(ready_i));
      pv   = valid_o;
      held = d_o;
    end
  end

  initial begin
    int acc, r, n;
    valid_i = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_ready_o", 128'(ready_o), 128'(0));
    @(posedge clk);
    #1 rst_ni = 1'b1;
    valid_i = 1'b0;
    @(negedge clk);
    chk("reset_valid_o", 128'(valid_o), 128'(0));
    chk("reset_d_o", d_o, '0);
    chk("idle_ready_o", 128'(ready_o), 128'(1));
    @(posedge clk);
    #1;

    issue(p16(1, 2, 3, 4), p16(5, 6, 7, 8), '0, 8, 8, 0, 0, 1, p32(19, 22, 43, 50), acc);
    repeat (5) begin
      @(negedge clk);
      chk("busy_ready_o", 128'(ready_o), 128'(0));
    end
    drain();
    issue(p16(1, 2, 3, 4), p16(5, 6, 7, 8), p32('hDEAD, 'hDEAD, 'hDEAD, 'hDEAD),
          8, 8, 0, 1, 1, p32(38, 44, 86, 100), acc);
    drain();
    issue(p16(-1, 2, 3, -4), p16(5, -6, 7, -8), p32(100, 0, 0, -100),
          4, 4, 1, 0, 1, p32(109, -10, -13, -86), acc);
    drain();
    issue(p16(-2, 1, 1, 0), p16(32767, -32768, 1, 1), '0,
          2, 16, 1, 0, 1, p32(-65533, 65537, 32767, -32768), acc);
    drain();
    issue(p16(1, 0, 0, 0), p16(1, 0, 0, 0), p32(32'h7FFFFFFF, 0, 0, 0),
          8, 8, 0, 0, 1, p32(32'sh80000000, 0, 0, 0), acc);
    drain();
    issue(p16(-32768, 1, 0, 0), p16(2, 0, 0, 0), '0, 0, 16, 1, 0, 1, p32(-65536, 0, 0, 0), acc);
    drain();
    issue(p16(8, 5, 1, 0), p16(1, 2, 3, 4), '0, 3, 8, 1, 0, 1, p32(7, 4, 1, 2), acc);
    drain();

    // Backpressure then same-cycle hand-off.
    ready_cmd = 1'b0;
    issue(p16(1, 2, 3, 4), p16(5, 6, 7, 8), '0, 8, 8, 0, 0, 1, p32(19, 22, 43, 50), acc);
    n = 0;
    while (!valid_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("bp_valid_seen", 128'(valid_o), 128'(1));
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
    r = cyc;
    ready_cmd = 1'b1;
    issue(p16(-1, 2, 3, -4), p16(5, -6, 7, -8), p32(100, 0, 0, -100),
          4, 4, 1, 0, 1, p32(109, -10, -13, -86), acc);
    chk("handoff_accept", 128'(acc), 128'(r + 1));
    drain();

    // Abort mid-COMPUTE.
    issue({$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
          16, 16, 1, 0, 0, '0, acc);
    repeat (3) @(posedge clk);
    #1 rst_ni = 1'b0;
    @(posedge clk);
    #1 rst_ni = 1'b1;
    void'(exp_d.pop_back());
    void'(exp_cyc.pop_back());
    last_d = '0;
    @(negedge clk);
    chk("abort_valid_o", 128'(valid_o), 128'(0));
    chk("abort_d_o", d_o, '0);
    repeat (12) @(negedge clk);
    @(posedge clk);
    #1;
    issue(p16(1, 2, 3, 4), p16(5, 6, 7, 8), p32(999, 999, 999, 999),
          8, 8, 0, 1, 1, p32(19, 22, 43, 50), acc);
    drain();

    rnd_rdy = 1'b1;
    for (int i = 0; i < 30; i++) begin
      issue({$urandom, $urandom}, {$urandom, $urandom},
            {$urandom, $urandom, $urandom, $urandom},
            int'($urandom_range(0, 20)), int'($urandom_range(0, 20)),
            1'($urandom), 1'($urandom), 0, '0, acc);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
    drain();
    rnd_rdy = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
